// File: rtl/qr_feed_scheduler.sv
// qr_feed_scheduler: skews 4-column rows into the systolic QR array, inserts inter-matrix bubbles
// and throttles matrices by in-flight credits. Define QR_SCHED_STATS_EN for the statistics outputs.
`default_nettype none

module qr_feed_scheduler #(
    parameter int CORDIC_PIPE_STAGE = 8,
    parameter int DATA_W            = 20,
    parameter int ROWS              = 4,
    parameter int GAP_CYCLES        = 1,
    parameter int MAX_INFLIGHT      = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data1,
    input  logic signed [DATA_W-1:0] s_data2,
    input  logic signed [DATA_W-1:0] s_data3,
    input  logic signed [DATA_W-1:0] s_data4,
    output logic                     ArrInValid,
    output logic signed [DATA_W-1:0] ArrInData1,
    output logic signed [DATA_W-1:0] ArrInData2,
    output logic signed [DATA_W-1:0] ArrInData3,
    output logic signed [DATA_W-1:0] ArrInData4,
    input  logic                     ArrOutValid,
    output logic                     busy,
    output logic                     err
`ifdef QR_SCHED_STATS_EN
    ,
    output logic [15:0]              stat_issued,
    output logic [15:0]              stat_done,
    output logic [15:0]              stat_stall
`endif
);

    localparam int ROW_W = $clog2(ROWS) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
    localparam int INF_W = $clog2(MAX_INFLIGHT) + 1;
    localparam int P     = CORDIC_PIPE_STAGE;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [INF_W-1:0] INF_MAX  = INF_W'(MAX_INFLIGHT);
    localparam logic [INF_W-1:0] INF_ONE  = INF_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [ROW_W-1:0]   row_cnt, row_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [INF_W-1:0]   inflight;
    logic               accept;
    logic               first_acc;
    logic               credit_ret;
    logic               stray_done;
    logic               underrun;
    logic               last_row;

    logic signed [DATA_W-1:0] col_in  [4];
    logic signed [DATA_W-1:0] col_out [4];

    // Ready is held low during reset even though the registers already read IDLE.
    assign s_ready    = Reset && ((state == FEED) || ((state == IDLE) && (inflight < INF_MAX)));
    assign accept     = s_valid && s_ready;
    assign first_acc  = accept && (state == IDLE);
    assign credit_ret = ArrOutValid && (inflight != '0);
    assign stray_done = ArrOutValid && (inflight == '0);
    assign busy       = (state != IDLE) || (inflight != '0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            row_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            row_cnt <= row_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row_cnt;
        gap_nxt   = gap_cnt;
        underrun  = 1'b0;
        last_row  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    row_nxt = ROW_ONE;
                    if (ROWS == 1) last_row  = 1'b1;
                    else           state_nxt = FEED;
                end
            end
            FEED: begin
                if (accept) begin
                    row_nxt = row_cnt + ROW_ONE;
                    if (row_cnt == LAST_ROW) last_row = 1'b1;
                end else begin
                    underrun = 1'b1;
                end
            end
            GAP: begin
                gap_nxt = gap_cnt - GAP_ONE;
                if (gap_cnt <= GAP_ONE) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (last_row) begin
            if (GAP_CYCLES == 0) begin
                state_nxt = IDLE;
            end else begin
                state_nxt = GAP;
                gap_nxt   = GAP_LOAD;
            end
        end
    end

    // First-row accept cannot happen at the limit, so inflight never overshoots.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            if (first_acc && !credit_ret)      inflight <= inflight + INF_ONE;
            else if (!first_acc && credit_ret) inflight <= inflight - INF_ONE;
            if (underrun || stray_done)        err <= 1'b1;
        end
    end

    assign col_in[0] = s_data1;
    assign col_in[1] = s_data2;
    assign col_in[2] = s_data3;
    assign col_in[3] = s_data4;

    for (genvar c = 0; c < 4; c++) begin : g_col
        localparam int DEPTH = (c == 0) ? 1 : (c == 1) ? 2 : (c == 2) ? 3 + P : 4 + 2 * P;
        logic signed [DATA_W-1:0] line [DEPTH];

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                for (int i = 0; i < DEPTH; i++) line[i] <= '0;
            end else begin
                line[0] <= accept ? col_in[c] : '0;
                for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
            end
        end

        assign col_out[c] = line[DEPTH-1];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) ArrInValid <= 1'b0;
        else        ArrInValid <= accept;
    end

    assign ArrInData1 = col_out[0];
    assign ArrInData2 = col_out[1];
    assign ArrInData3 = col_out[2];
    assign ArrInData4 = col_out[3];

`ifdef QR_SCHED_STATS_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stat_issued <= '0;
            stat_done   <= '0;
            stat_stall  <= '0;
        end else begin
            if (first_acc)            stat_issued <= stat_issued + 16'd1;
            if (ArrOutValid)          stat_done   <= stat_done + 16'd1;
            if (s_valid && !s_ready)  stat_stall  <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_qr_feed_scheduler.sv
// tb_qr_feed_scheduler: randomized episodes against a rule-level model of skew, gaps and credits.
`default_nettype none

module tb_qr_feed_scheduler;

    localparam int P    = 8;
    localparam int DW   = 20;
    localparam int NR   = 4;
    localparam int GAP  = 1;
    localparam int MAXI = 4;
    localparam int MAXC = 4000;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic s_valid = 1'b0;
    logic ArrOutValid = 1'b0;
    logic s_ready, ArrInValid, busy, err;
    logic signed [DW-1:0] sd [4];
    logic signed [DW-1:0] d1, d2, d3, d4;
    logic signed [DW-1:0] dout [4];
`ifdef QR_SCHED_STATS_EN
    logic [15:0] stat_issued, stat_done, stat_stall;
`endif

    always #5 Clk = ~Clk;

    initial for (int k = 0; k < 4; k++) sd[k] = '0;

    qr_feed_scheduler #(
        .CORDIC_PIPE_STAGE(P), .DATA_W(DW), .ROWS(NR), .GAP_CYCLES(GAP), .MAX_INFLIGHT(MAXI)
    ) dut (
        .Clk(Clk), .Reset(Reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data1(sd[0]), .s_data2(sd[1]), .s_data3(sd[2]), .s_data4(sd[3]),
        .ArrInValid(ArrInValid),
        .ArrInData1(d1), .ArrInData2(d2), .ArrInData3(d3), .ArrInData4(d4),
        .ArrOutValid(ArrOutValid), .busy(busy), .err(err)
`ifdef QR_SCHED_STATS_EN
        , .stat_issued(stat_issued), .stat_done(stat_done), .stat_stall(stat_stall)
`endif
    );

    assign dout[0] = d1;
    assign dout[1] = d2;
    assign dout[2] = d3;
    assign dout[3] = d4;

    int checks = 0;
    int failures = 0;
    int n = 0;
    int valid_from = 0;

    // Behavioural model state
    int m_rows, m_gap, m_cred;
    bit m_err;
    logic [15:0] m_iss, m_done, m_stall;
    bit acc_hist [MAXC];
    logic signed [DW-1:0] dat_hist [MAXC][4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic int dly(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 3 + P : 4 + 2 * P;
    endfunction

    function automatic logic signed [DW-1:0] exp_col(input int k);
        int idx = n - dly(k);
        if (idx < valid_from || idx < 0 || !acc_hist[idx]) return '0;
        return dat_hist[idx][k];
    endfunction

    function automatic bit exp_valid();
        int idx = n - 1;
        if (idx < valid_from || idx < 0) return 1'b0;
        return acc_hist[idx];
    endfunction

    task automatic model_reset();
        m_rows = 0; m_gap = 0; m_cred = 0; m_err = 1'b0;
        m_iss = '0; m_done = '0; m_stall = '0;
    endtask

    // One cycle, entered and left on a falling edge.
    task automatic step(input int pv, input int pa, input bit force_v, input bit do_rst);
        bit v, a, ready, acc, first, ret;
        for (int k = 0; k < 4; k++) chk($sformatf("data%0d", k + 1), 64'(dout[k]), 64'(exp_col(k)));
        chk("in_valid", 64'(ArrInValid), 64'(exp_valid()));
        chk("busy", 64'(busy), 64'(m_rows > 0 || m_gap > 0 || m_cred > 0));
        chk("err", 64'(err), 64'(m_err));
`ifdef QR_SCHED_STATS_EN
        chk("stat_issued", 64'(stat_issued), 64'(m_iss));
        chk("stat_done", 64'(stat_done), 64'(m_done));
        chk("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
        v = force_v || ($urandom_range(99) < pv);
        a = ($urandom_range(99) < pa);
        for (int k = 0; k < 4; k++) sd[k] = DW'($urandom);
        if (do_rst) begin
            s_valid = 1'b0;
            ArrOutValid = 1'b0;
            #2 Reset = 1'b0;
            #1;
            chk("rst_in_valid", 64'(ArrInValid), 64'(0));
            for (int k = 0; k < 4; k++) chk($sformatf("rst_data%0d", k + 1), 64'(dout[k]), 64'(0));
            chk("rst_s_ready", 64'(s_ready), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_err", 64'(err), 64'(0));
            acc_hist[n] = 1'b0;
            valid_from = n;
            model_reset();
            @(negedge Clk);
            Reset = 1'b1;
            n++;
        end else begin
            s_valid = v;
            ArrOutValid = a;
            #1;
            ready = (m_gap > 0) ? 1'b0 : ((m_rows > 0) ? 1'b1 : (m_cred < MAXI));
            chk("s_ready", 64'(s_ready), 64'(ready));
            acc = v && ready;
            acc_hist[n] = acc;
            for (int k = 0; k < 4; k++) dat_hist[n][k] = sd[k];
            if (v && !ready) m_stall++;
            if (a) m_done++;
            first = acc && m_rows == 0 && m_gap == 0;
            if (m_gap > 0) begin
                m_gap--;
            end else if (m_rows > 0) begin
                if (acc) begin
                    m_rows++;
                    if (m_rows == NR) begin m_rows = 0; m_gap = GAP; end
                end else begin
                    m_err = 1'b1;
                end
            end else if (acc) begin
                m_iss++;
                m_rows = 1;
                if (NR == 1) begin m_rows = 0; m_gap = GAP; end
            end
            ret = a && m_cred > 0;
            if (a && m_cred == 0) m_err = 1'b1;
            m_cred = m_cred + int'(first) - int'(ret);
            @(negedge Clk);
            n++;
        end
    endtask

    initial begin
        bit rst_done;
        model_reset();
        repeat (2) @(negedge Clk);
        Reset = 1'b1;

        // Single matrix on consecutive cycles, then drain the skew
        for (int i = 0; i < NR; i++) step(0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(0, 0, 1'b0, 1'b0);

        // Back-to-back matrices into the credit limit, then credit returns
        step(0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) step(100, 0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(100, 30, 1'b1, 1'b0);

        // Random mix with stray strobes and underruns
        step(0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 500; i++) step(92, 12, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) step(55, 20, 1'b0, 1'b0);

        // Reset landing mid-matrix on row 2
        step(0, 0, 1'b0, 1'b1);
        rst_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!rst_done && i > 10 && m_rows == 2) begin
                step(0, 0, 1'b0, 1'b1);
                rst_done = 1'b1;
            end else begin
                step(95, 20, 1'b0, 1'b0);
            end
        end
        chk("mid_feed_reset_hit", 64'(rst_done), 64'(1));
        for (int i = 0; i < 100; i++) step(100, 25, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
